// File: rtl/dram_arbiter_if.sv
// Client and controller signal bundle for the video/CPU DRAM arbiter.
// The arbiter sits on the slave side; clients and controller on the master side.
interface dram_arbiter_if;
  logic        vid_req;
  logic [20:0] vid_addr;
  logic        vid_ack;

  logic        cpu_req;
  logic [20:0] cpu_addr;
  logic        cpu_rnw;
  logic [15:0] cpu_wrdata;
  logic [1:0]  cpu_bsel;
  logic        cpu_ack;

  logic [15:0] rddata;
  logic        vid_strb;
  logic        cpu_strb;

  logic        req;
  logic [20:0] addr;
  logic        rnw;
  logic [1:0]  bsel;
  logic [15:0] wrdata;

  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_addr, cpu_rnw,
    input  cpu_wrdata, cpu_bsel,
    output vid_ack, cpu_ack,
    output rddata, vid_strb, cpu_strb,
    output req, addr, rnw, bsel, wrdata
  );

  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_addr, cpu_rnw,
    output cpu_wrdata, cpu_bsel,
    input  vid_ack, cpu_ack,
    input  rddata, vid_strb, cpu_strb,
    input  req, addr, rnw, bsel, wrdata
  );
endinterface

// File: rtl/dram_arbiter.sv
// Two-client DRAM arbiter: video has priority, the CPU wins after
// CPU_MAXWAIT denied slots. One DRAM cycle spans the c0..c3 phases.
module dram_arbiter #(
  parameter int CPU_MAXWAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0,
  input  logic        c1,
  input  logic        c2,
  input  logic        c3,
  input  logic [15:0] dram_rd,
  dram_arbiter_if.slave bus
);

  localparam logic [3:0] MAXW = 4'(CPU_MAXWAIT);

  logic [3:0] wait_cnt;
  logic       pend_vid;
  logic       pend_cpu;
  logic       grant_cpu;
  logic       grant_vid;

  // c0/c1 only exist to keep the phase ring complete at the port
  logic unused_phase;
  assign unused_phase = c0 | c1;

  always_comb begin
    grant_cpu = 1'b0;
    grant_vid = 1'b0;
    if (c3 && !rst) begin
      if (bus.cpu_req &&
          (wait_cnt == MAXW || !bus.vid_req))
        grant_cpu = 1'b1;
      else if (bus.vid_req)
        grant_vid = 1'b1;
    end
  end

  always_comb begin
    bus.req  = 1'b0;
    bus.addr = '0;
    bus.rnw  = 1'b1;
    bus.bsel = 2'b11;
    unique case (1'b1)
      grant_cpu: begin
        bus.req  = 1'b1;
        bus.addr = bus.cpu_addr;
        bus.rnw  = bus.cpu_rnw;
        bus.bsel = bus.cpu_bsel;
      end
      grant_vid: begin
        bus.req  = 1'b1;
        bus.addr = bus.vid_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt     <= '0;
      pend_vid     <= 1'b0;
      pend_cpu     <= 1'b0;
      bus.vid_ack  <= 1'b0;
      bus.cpu_ack  <= 1'b0;
      bus.vid_strb <= 1'b0;
      bus.cpu_strb <= 1'b0;
      bus.rddata   <= '0;
      bus.wrdata   <= '0;
    end else begin
      bus.vid_ack  <= grant_vid;
      bus.cpu_ack  <= grant_cpu;
      bus.vid_strb <= 1'b0;
      bus.cpu_strb <= 1'b0;
      if (grant_cpu && !bus.cpu_rnw)
        bus.wrdata <= bus.cpu_wrdata;
      if (c3) begin
        if (grant_cpu || !bus.cpu_req)
          wait_cnt <= '0;
        else if (grant_vid && wait_cnt != MAXW)
          wait_cnt <= wait_cnt + 4'd1;
        pend_vid <= grant_vid;
        pend_cpu <= grant_cpu && bus.cpu_rnw;
      end else if (c2) begin
        // read data is on the pins at c2 of the cycle after the grant
        if (pend_vid || pend_cpu)
          bus.rddata <= dram_rd;
        bus.vid_strb <= pend_vid;
        bus.cpu_strb <= pend_cpu;
        pend_vid     <= 1'b0;
        pend_cpu     <= 1'b0;
      end
    end
  end

endmodule
